// File: rtl/fram_portb_arbiter.sv
// fram_portb_arbiter: shares feature SRAM port B between decoder reads and buffered CU writebacks
// Ports: rd_* decoder read stream (grant, 1-cycle data return); wr_* CU writeback into the write FIFO;
// bram_* flattened per-bank port B drive (bank 0 in LSBs); idle/wb_level/overflow status.
module fram_portb_arbiter #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_NUM        = 4,
  parameter int BANK_ADDR_WIDTH = ADDR_WIDTH - $clog2(BANK_NUM),
  parameter int WB_DEPTH        = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rd_req,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic                                 rd_gnt,
  output logic                                 rd_rvalid,
  output logic [DATA_WIDTH-1:0]                rd_rdata,
  input  logic                                 wr_req,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 wr_ready,
  output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]  bram_addr,
  output logic [BANK_NUM*DATA_WIDTH-1:0]       bram_wdata,
  output logic [BANK_NUM-1:0]                  bram_we,
  output logic [BANK_NUM-1:0]                  bram_en,
  input  logic [BANK_NUM*DATA_WIDTH-1:0]       bram_rdata,
  output logic                                 idle,
  output logic [$clog2(WB_DEPTH):0]            wb_level,
  output logic                                 overflow
);
  localparam int LB = $clog2(BANK_NUM);
  localparam int LW = $clog2(WB_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [ADDR_WIDTH-1:0] fa_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] fd_q [WB_DEPTH];
  logic [LW-1:0] rp_q, wp_q;
  logic [LW:0] lvl_q, lvl_d;
  logic [SW-1:0] sc_q, sc_d;
  logic rv_q, ovf_q;
  logic [LB-1:0] rb_q;
  logic hit, ne, starve, issue, push;
  logic [ADDR_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_d;
  logic [LB-1:0] rd_bank, hd_bank;
  // RAW check against every occupied FIFO slot, walking from the head
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++)
      if ((LW+1)'(i) < lvl_q && fa_q[rp_q + LW'(i)] == rd_addr) hit = 1'b1;
  end
  assign head_a   = fa_q[rp_q];
  assign head_d   = fd_q[rp_q];
  assign ne       = lvl_q != '0;
  assign rd_bank  = rd_addr[LB-1:0];
  assign hd_bank  = head_a[LB-1:0];
  assign starve   = sc_q == SW'(STARVE_LIMIT);
  assign rd_gnt   = rd_req & ~hit & ~starve & ~rst;
  assign issue    = ne & (~rd_gnt | hd_bank != rd_bank);
  // level never exceeds WB_DEPTH (a power of 2), so its MSB alone means full
  assign wr_ready = ~lvl_q[LW];
  assign push     = wr_req & wr_ready;
  assign lvl_d    = lvl_q + (LW+1)'(push) - (LW+1)'(issue);
  // a non-empty FIFO that does not issue is, by construction, blocked by the read
  assign sc_d     = (~ne | issue) ? '0 : sc_q + 1'b1;
  always_comb begin
    bram_en    = '0;
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (issue && hd_bank == LB'(b)) begin
        bram_en[b] = 1'b1;
        bram_we[b] = 1'b1;
        bram_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = BANK_ADDR_WIDTH'(head_a[ADDR_WIDTH-1:LB]);
        bram_wdata[b*DATA_WIDTH +: DATA_WIDTH] = head_d;
      end else if (rd_gnt && rd_bank == LB'(b)) begin
        bram_en[b] = 1'b1;
        bram_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = BANK_ADDR_WIDTH'(rd_addr[ADDR_WIDTH-1:LB]);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q  <= '0;
      wp_q  <= '0;
      lvl_q <= '0;
      sc_q  <= '0;
      rv_q  <= 1'b0;
      rb_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      rp_q  <= rp_q + LW'(issue);
      wp_q  <= wp_q + LW'(push);
      lvl_q <= lvl_d;
      sc_q  <= sc_d;
      rv_q  <= rd_gnt;
      rb_q  <= rd_bank;
      ovf_q <= ovf_q | (wr_req & ~wr_ready);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wp_q] <= wr_addr;
      fd_q[wp_q] <= wr_data;
    end
  end
  assign rd_rvalid = rv_q;
  assign rd_rdata  = rv_q ? bram_rdata[int'(rb_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign idle      = ~ne & ~rv_q;
  assign wb_level  = lvl_q;
  assign overflow  = ovf_q;
endmodule
